// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and its consumers (slave).
interface vga_timing_if #(
  parameter int CW = 11
);
  logic          pix_ce;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_ce,
    output h_count, v_count, de, hsync, vsync, hblank, vblank, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  h_count, v_count, de, hsync, vsync, hblank, vblank, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank, DE and strobes,
// stepping once per clk cycle that has pix_ce high.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Non-zero back porches keep the reset position (last pixel/line) outside the sync pulses.
  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_chk
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (H_BP < 1 || V_BP < 1) begin : g_bp_chk
    $error("vga_timing_gen: H_BP and V_BP must be at least 1");
  end

  function automatic logic in_range(input logic [CW-1:0] c, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi_excl);
    return (c >= lo) && (c < hi_excl);
  endfunction

  logic [CW-1:0] h_cnt_p1, v_cnt_p1;
  logic          de_p1, hs_p1, vs_p1, hb_p1, vb_p1, ls_p1, fs_p1;
  logic [CW-1:0] h_nxt_p0, v_nxt_p0;

  // Stage 0: next raster position
  always_comb begin
    h_nxt_p0 = h_cnt_p1 + 1'b1;
    v_nxt_p0 = v_cnt_p1;
    if (h_cnt_p1 == H_LAST) begin
      h_nxt_p0 = '0;
      v_nxt_p0 = (v_cnt_p1 == V_LAST) ? '0 : v_cnt_p1 + 1'b1;
    end
  end

  // Stage 1: counters and every derived flag decoded from the same next position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_p1 <= H_LAST;
      v_cnt_p1 <= V_LAST;
      de_p1    <= 1'b0;
      hs_p1    <= ~HS_POL;
      vs_p1    <= ~VS_POL;
      hb_p1    <= 1'b1;
      vb_p1    <= 1'b1;
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end else if (tim.pix_ce) begin
      h_cnt_p1 <= h_nxt_p0;
      v_cnt_p1 <= v_nxt_p0;
      de_p1    <= (h_nxt_p0 < H_ACT) && (v_nxt_p0 < V_ACT);
      hs_p1    <= in_range(h_nxt_p0, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
      vs_p1    <= in_range(v_nxt_p0, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
      hb_p1    <= (h_nxt_p0 >= H_ACT);
      vb_p1    <= (v_nxt_p0 >= V_ACT);
      ls_p1    <= (h_nxt_p0 == '0);
      fs_p1    <= (h_nxt_p0 == '0) && (v_nxt_p0 == '0);
    end else begin
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end
  end

  assign tim.h_count     = h_cnt_p1;
  assign tim.v_count     = v_cnt_p1;
  assign tim.de          = de_p1;
  assign tim.hsync       = hs_p1;
  assign tim.vsync       = vs_p1;
  assign tim.hblank      = hb_p1;
  assign tim.vblank      = vb_p1;
  assign tim.line_start  = ls_p1;
  assign tim.frame_start = fs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-raster instance share clk/reset/pix_ce.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.CW(11)) dif ();
  vga_timing_if #(.CW(3))  sif ();

  vga_timing_gen dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .tim   (dif)
  );

  vga_timing_gen #(
    .CW(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .tim   (sif)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic de, hs, vs, hb, vb, ls, fs;
  } obs_t;

  obs_t obs_d, obs_s;
  assign obs_d = {dif.h_count, dif.v_count, dif.de, dif.hsync, dif.vsync,
                  dif.hblank, dif.vblank, dif.line_start, dif.frame_start};
  assign obs_s = {8'd0, sif.h_count, 8'd0, sif.v_count, sif.de, sif.hsync, sif.vsync,
                  sif.hblank, sif.vblank, sif.line_start, sif.frame_start};

  obs_t q_d[$];
  obs_t q_s[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int mh_d = 0, mv_d = 0, mh_s = 0, mv_s = 0;
  bit ls_d = 0, fs_d = 0, ls_s = 0, fs_s = 0;

  function automatic obs_t expect_out(int h, int v, int ha, int hfp, int hsw, int va, int vfp,
                                      int vsw, bit hpol, bit vpol, bit ls, bit fs);
    obs_t e;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.de = (h < ha) && (v < va);
    e.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
    e.vs = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
    e.hb = (h >= ha);
    e.vb = (v >= va);
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  task automatic adv(inout int h, inout int v, inout bit ls, inout bit fs,
                     input int ht, input int vt, input bit ce, input bit rn);
    if (!rn) begin
      h = ht - 1; v = vt - 1; ls = 0; fs = 0;
    end else if (ce) begin
      if (h == ht - 1) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
      ls = (h == 0);
      fs = (h == 0) && (v == 0);
    end else begin
      ls = 0; fs = 0;
    end
  endtask

  // Drive one clk of stimulus and queue what both instances must show after the edge.
  task automatic step(input bit ce, input bit rn);
    rst_n      = rn;
    dif.pix_ce = ce;
    sif.pix_ce = ce;
    adv(mh_d, mv_d, ls_d, fs_d, 1344, 806, ce, rn);
    adv(mh_s, mv_s, ls_s, fs_s, 8, 6, ce, rn);
    q_d.push_back(expect_out(mh_d, mv_d, 1024, 24, 136, 768, 3, 6, 1'b0, 1'b0, ls_d, fs_d));
    q_s.push_back(expect_out(mh_s, mv_s, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1, ls_s, fs_s));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL reset_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL reset_small: got %h want %h", obs_s, e); end
    end
    n_cmp++;
    if (dif.h_count !== 11'd1343 || dif.v_count !== 11'd805 || dif.hsync !== 1'b1 ||
        dif.vsync !== 1'b1 || dif.de !== 1'b0 || dif.frame_start !== 1'b0) begin
      n_err++; $display("FAIL reset_const: got h=%0d v=%0d hs=%b vs=%b", dif.h_count,
                        dif.v_count, dif.hsync, dif.vsync);
    end
  endtask

  task automatic test_default_line();
    obs_t e;
    int de_cnt = 0, hs_cnt = 0, first_hs = -1;
    for (int i = 0; i < 1344; i++) begin
      step(1'b1, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL line_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL line_small: got %h want %h", obs_s, e); end
      if (i == 0) begin
        n_cmp++;
        if (dif.h_count !== 11'd0 || dif.v_count !== 11'd0 || dif.de !== 1'b1 ||
            dif.line_start !== 1'b1 || dif.frame_start !== 1'b1) begin
          n_err++; $display("FAIL first_pix: got %h want h=0 v=0 de=1 ls=1 fs=1", obs_d);
        end
      end
      if (dif.de === 1'b1) de_cnt++;
      if (dif.hsync === 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(dif.h_count);
      end
    end
    n_cmp++;
    if (de_cnt != 1024) begin n_err++; $display("FAIL de_width: got %0d want 1024", de_cnt); end
    n_cmp++;
    if (hs_cnt != 136) begin n_err++; $display("FAIL hs_width: got %0d want 136", hs_cnt); end
    n_cmp++;
    if (first_hs != 1048) begin n_err++; $display("FAIL hs_start: got %0d want 1048", first_hs); end
  endtask

  task automatic test_small_frame();
    obs_t e;
    int last_fs = -1, last_ls = -1, vs_cnt = 0, fs_per = 0;
    for (int i = 0; i < 144; i++) begin
      step(1'b1, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL frame_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL frame_small: got %h want %h", obs_s, e); end
      if (sif.vsync === 1'b1) vs_cnt++;
      if (sif.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          fs_per++; n_cmp++;
          if (i - last_fs != 48) begin
            n_err++; $display("FAIL fs_period: got %0d want 48", i - last_fs);
          end
        end
        last_fs = i;
      end
      if (sif.line_start === 1'b1) begin
        if (last_ls >= 0) begin
          n_cmp++;
          if (i - last_ls != 8) begin
            n_err++; $display("FAIL ls_period: got %0d want 8", i - last_ls);
          end
        end
        last_ls = i;
      end
    end
    n_cmp++;
    if (fs_per < 1) begin n_err++; $display("FAIL fs_seen: got %0d periods want >=1", fs_per); end
    n_cmp++;
    if (vs_cnt != 24) begin n_err++; $display("FAIL vs_small: got %0d want 24", vs_cnt); end
  endtask

  task automatic test_ce_div3();
    obs_t e;
    int hs_cnt = 0, vs_cnt = 0, dbl = 0;
    logic prev_ls_s = 1'b0, prev_ls_d = 1'b0;
    for (int i = 0; i < 432; i++) begin
      step(i % 3 == 0, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL div3_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL div3_small: got %h want %h", obs_s, e); end
      if (sif.hsync === 1'b1) hs_cnt++;
      if (sif.vsync === 1'b1) vs_cnt++;
      if ((prev_ls_s && sif.line_start === 1'b1) || (prev_ls_d && dif.line_start === 1'b1)) dbl++;
      prev_ls_s = (sif.line_start === 1'b1);
      prev_ls_d = (dif.line_start === 1'b1);
    end
    n_cmp++;
    if (hs_cnt != 108) begin n_err++; $display("FAIL div3_hs: got %0d want 108", hs_cnt); end
    n_cmp++;
    if (vs_cnt != 72) begin n_err++; $display("FAIL div3_vs: got %0d want 72", vs_cnt); end
    n_cmp++;
    if (dbl != 0) begin n_err++; $display("FAIL strobe_width: got %0d wide strobes want 0", dbl); end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    for (int i = 0; i < 1400 && mh_d != 500; i++) begin
      step(1'b1, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL seek_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL seek_small: got %h want %h", obs_s, e); end
    end
    n_cmp++;
    if (dif.h_count !== 11'd500) begin
      n_err++; $display("FAIL seek_pos: got h=%0d want 500", dif.h_count);
    end
    step(1'b1, 1'b0);
    e = q_d.pop_front(); n_cmp++;
    if (obs_d !== e) begin n_err++; $display("FAIL midrst_dflt: got %h want %h", obs_d, e); end
    e = q_s.pop_front(); n_cmp++;
    if (obs_s !== e) begin n_err++; $display("FAIL midrst_small: got %h want %h", obs_s, e); end
    n_cmp++;
    if (sif.h_count !== 3'd7 || sif.v_count !== 3'd5 || sif.hsync !== 1'b0 ||
        sif.vsync !== 1'b0 || sif.line_start !== 1'b0 || sif.frame_start !== 1'b0) begin
      n_err++; $display("FAIL midrst_const: got %h want h=7 v=5 syncs 0 strobes 0", obs_s);
    end
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL restart_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL restart_small: got %h want %h", obs_s, e); end
    end
    n_cmp++;
    if (dif.h_count !== 11'd0 || dif.v_count !== 11'd0 || dif.frame_start !== 1'b1) begin
      n_err++; $display("FAIL restart_pos: got %h want h=0 v=0 fs=1", obs_d);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int ls_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      e = q_d.pop_front(); n_cmp++;
      if (obs_d !== e) begin n_err++; $display("FAIL b2b_dflt: got %h want %h", obs_d, e); end
      e = q_s.pop_front(); n_cmp++;
      if (obs_s !== e) begin n_err++; $display("FAIL b2b_small: got %h want %h", obs_s, e); end
      if (sif.line_start === 1'b1) ls_cnt++;
    end
    n_cmp++;
    if (ls_cnt != 2) begin n_err++; $display("FAIL b2b_ls_count: got %0d want 2", ls_cnt); end
    step(1'b0, 1'b1);
    e = q_s.pop_front(); void'(q_d.pop_front()); n_cmp++;
    if (obs_s !== e) begin n_err++; $display("FAIL hold_small: got %h want %h", obs_s, e); end
  endtask

  initial begin
    dif.pix_ce = 1'b0;
    sif.pix_ce = 1'b0;
    test_reset();
    test_default_line();
    test_small_frame();
    test_ce_div3();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
